// File: rtl/selen_wb_pkg.sv
// Shared types for the Wishbone memory arbiter.
//   arb_state_e  : arbiter FSM state
//   arb_master_e : which master held the most recent grant (round-robin memory)
package selen_wb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_master_e;
endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-timeout watchdog for the Wishbone arbiter.
// Counts cycles in which a strobe is outstanding without a slave response and
// pulses o_expire on the TIMEOUT-th such cycle. TIMEOUT = 0 disables it.
// Ports:
//   clk, rst   clock, async active-high reset
//   i_clr      clear the count (slave responded, or no grant held)
//   i_active   strobe outstanding with no ack/err this cycle
//   o_expire   combinational timeout pulse (only while i_active)
module wb_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_active,
  output logic o_expire
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{clk, rst, i_clr, i_active};
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0] r_cnt;

      // >= rather than == so a stuck count can never slip past the limit.
      assign o_expire = i_active && (r_cnt >= LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_cnt <= '0;
        else if (i_clr)                   r_cnt <= '0;
        else if (i_active && r_cnt < LAST) r_cnt <= r_cnt + 1'b1;
      end
    end
  endgenerate
endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter: CPU instruction (mi_*) and data (md_*) masters
// share one slave port (s_*). Round-robin on ties, grant held for the whole
// cyc burst, watchdog turns a hung strobe into err for the granted master.
// Ports:
//   clk, rst                        clock, async active-high reset
//   mi_cyc/stb/we/adr/dat_i/sel     I master request;  mi_dat_o/ack/err response
//   md_*                            same for D master
//   s_cyc/stb/we/adr/dat_o/sel      slave request;     s_dat_i/ack/err response
module wb_mem_arbiter
  import selen_wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mi_cyc,
  input  logic                mi_stb,
  input  logic                mi_we,
  input  logic [ADDR_W-1:0]   mi_adr,
  input  logic [DATA_W-1:0]   mi_dat_i,
  input  logic [DATA_W/8-1:0] mi_sel,
  output logic [DATA_W-1:0]   mi_dat_o,
  output logic                mi_ack,
  output logic                mi_err,
  input  logic                md_cyc,
  input  logic                md_stb,
  input  logic                md_we,
  input  logic [ADDR_W-1:0]   md_adr,
  input  logic [DATA_W-1:0]   md_dat_i,
  input  logic [DATA_W/8-1:0] md_sel,
  output logic [DATA_W-1:0]   md_dat_o,
  output logic                md_ack,
  output logic                md_err,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack,
  input  logic                s_err
);
  arb_state_e  r_state;
  arb_master_e r_last;
  logic        w_gi, w_gd, w_cyc_raw, w_stb_raw, w_expire;

  assign w_gi = (r_state == ARB_GNT_I);
  assign w_gd = (r_state == ARB_GNT_D);

  // Request mux: the granted master drives the slave, IDLE drives nothing.
  always_comb begin
    w_cyc_raw = 1'b0;
    w_stb_raw = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_o   = '0;
    s_sel     = '0;
    if (w_gi) begin
      w_cyc_raw = mi_cyc; w_stb_raw = mi_stb; s_we = mi_we;
      s_adr = mi_adr; s_dat_o = mi_dat_i; s_sel = mi_sel;
    end else if (w_gd) begin
      w_cyc_raw = md_cyc; w_stb_raw = md_stb; s_we = md_we;
      s_adr = md_adr; s_dat_o = md_dat_i; s_sel = md_sel;
    end
  end

  // On expiry the slave cycle is cut in the same cycle the err is raised.
  assign s_cyc = w_cyc_raw & ~w_expire;
  assign s_stb = w_stb_raw & ~w_expire;

  // Responses go to the granted master only.
  assign mi_ack   = w_gi & s_ack;
  assign md_ack   = w_gd & s_ack;
  assign mi_err   = w_gi & (s_err | w_expire);
  assign md_err   = w_gd & (s_err | w_expire);
  assign mi_dat_o = w_gi ? s_dat_i : '0;
  assign md_dat_o = w_gd ? s_dat_i : '0;

  // Every grant change passes through IDLE, so clearing there covers it.
  // A same-cycle ack/err keeps i_active low, so ack beats timeout.
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    ((r_state == ARB_IDLE) | s_ack | s_err),
    .i_active (w_stb_raw & ~s_ack & ~s_err),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_last  <= GNT_I;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (mi_cyc && md_cyc) r_state <= (r_last == GNT_I) ? ARB_GNT_D : ARB_GNT_I;
          else if (mi_cyc)      r_state <= ARB_GNT_I;
          else if (md_cyc)      r_state <= ARB_GNT_D;
        end
        ARB_GNT_I: if (!mi_cyc || w_expire) begin
          r_state <= ARB_IDLE;
          r_last  <= GNT_I;
        end
        ARB_GNT_D: if (!md_cyc || w_expire) begin
          r_state <= ARB_IDLE;
          r_last  <= GNT_D;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        mi_cyc, mi_stb, mi_we;
  logic [31:0] mi_adr, mi_dat_i, mi_dat_o;
  logic [3:0]  mi_sel;
  logic        mi_ack, mi_err;
  logic        md_cyc, md_stb, md_we;
  logic [31:0] md_adr, md_dat_i, md_dat_o;
  logic [3:0]  md_sel;
  logic        md_ack, md_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mi_cyc(mi_cyc), .mi_stb(mi_stb), .mi_we(mi_we), .mi_adr(mi_adr),
    .mi_dat_i(mi_dat_i), .mi_sel(mi_sel), .mi_dat_o(mi_dat_o), .mi_ack(mi_ack), .mi_err(mi_err),
    .md_cyc(md_cyc), .md_stb(md_stb), .md_we(md_we), .md_adr(md_adr),
    .md_dat_i(md_dat_i), .md_sel(md_sel), .md_dat_o(md_dat_o), .md_ack(md_ack), .md_err(md_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o), .s_sel(s_sel),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 2 units after.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mi_cyc = 0; mi_stb = 0; mi_we = 0; mi_adr = '0; mi_dat_i = '0; mi_sel = '0;
    md_cyc = 0; md_stb = 0; md_we = 0; md_adr = '0; md_dat_i = '0; md_sel = '0;
    s_dat_i = '0; s_ack = 0; s_err = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mi_cyc = 1; mi_stb = 1; md_cyc = 1; md_stb = 1; s_ack = 1; s_err = 1;
    mi_adr = 32'h10; md_adr = 32'h20; s_dat_i = 32'h1234_5678;
    step(); #1;
    checks++; if ({s_cyc, s_stb, s_we, mi_ack, mi_err, md_ack, md_err} !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b exp 0", {s_cyc, s_stb, s_we, mi_ack, mi_err, md_ack, md_err}); end
    checks++; if ({s_adr, mi_dat_o, md_dat_o} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", {s_adr, mi_dat_o, md_dat_o}); end
    apply_reset();
  endtask

  task automatic test_i_only();
    apply_reset();
    mi_cyc = 1; mi_stb = 1; mi_we = 0; mi_adr = 32'h100; mi_sel = 4'hF; #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL i_only_latency: s_cyc got %b exp 0", s_cyc); end
    step(); #1;
    checks++; if ({s_cyc, s_stb, s_adr, s_sel} !== {2'b11, 32'h100, 4'hF}) begin errors++; $display("FAIL i_only_grant: got %b%b %h %h exp 11 100 f", s_cyc, s_stb, s_adr, s_sel); end
    checks++; if (mi_ack !== 1'b0) begin errors++; $display("FAIL i_only_noack: mi_ack got %b exp 0", mi_ack); end
    step(); s_ack = 1; s_dat_i = 32'hDEAD_BEEF; #1;
    checks++; if ({mi_ack, md_ack, mi_dat_o, md_dat_o} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin errors++; $display("FAIL i_only_ack: got %b%b %h %h exp 10 deadbeef 0", mi_ack, md_ack, mi_dat_o, md_dat_o); end
    step(); s_ack = 0; mi_cyc = 0; mi_stb = 0; #1;
    checks++; if ({mi_ack, md_ack, s_cyc} !== 3'b000) begin errors++; $display("FAIL i_only_drop: got %b exp 000", {mi_ack, md_ack, s_cyc}); end
    step(); #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL i_only_idle: s_cyc got %b exp 0", s_cyc); end
  endtask

  task automatic test_round_robin();
    logic exp_d;
    apply_reset();
    mi_cyc = 1; mi_stb = 1; mi_adr = 32'h200;
    md_cyc = 1; md_stb = 1; md_adr = 32'h300;
    step();
    exp_d = 1'b1;  // last=I after reset, so D wins the first tie
    for (int r = 0; r < 4; r++) begin
      s_ack = 1; #1;
      checks++; if (s_adr !== (exp_d ? 32'h300 : 32'h200)) begin errors++; $display("FAIL rr_grant%0d: s_adr got %h exp %h", r, s_adr, exp_d ? 32'h300 : 32'h200); end
      checks++; if ({mi_ack, md_ack} !== (exp_d ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_ack%0d: mi/md got %b%b exp %b", r, mi_ack, md_ack, exp_d ? 2'b01 : 2'b10); end
      step(); s_ack = 0;
      if (exp_d) begin md_cyc = 0; md_stb = 0; end else begin mi_cyc = 0; mi_stb = 0; end
      step(); #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: s_cyc got %b exp 0", r, s_cyc); end
      if (exp_d) begin md_cyc = 1; md_stb = 1; end else begin mi_cyc = 1; mi_stb = 1; end
      step();
      exp_d = ~exp_d;
    end
    apply_reset();
  endtask

  task automatic test_burst_no_preempt();
    apply_reset();
    md_cyc = 1; md_stb = 1; md_we = 1; md_sel = 4'h3; md_adr = 32'h400;
    step();
    mi_cyc = 1; mi_stb = 1; mi_adr = 32'h800;
    for (int k = 0; k < 4; k++) begin
      md_adr = 32'h400 + 32'(4 * k); md_dat_i = 32'hA5A5_0000 + 32'(k); s_ack = 1; #1;
      checks++; if ({md_ack, mi_ack, s_we, s_sel} !== {3'b101, 4'h3}) begin errors++; $display("FAIL burst_ack%0d: got %b%b%b %h exp 101 3", k, md_ack, mi_ack, s_we, s_sel); end
      checks++; if ({s_adr, s_dat_o} !== {32'h400 + 32'(4 * k), 32'hA5A5_0000 + 32'(k)}) begin errors++; $display("FAIL burst_bus%0d: got %h %h", k, s_adr, s_dat_o); end
      step();
    end
    s_ack = 0; md_cyc = 0; md_stb = 0; md_we = 0;
    step(); #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL burst_idle: s_cyc got %b exp 0", s_cyc); end
    step(); #1;
    checks++; if ({s_cyc, s_adr} !== {1'b1, 32'h800}) begin errors++; $display("FAIL burst_i_grant: got %b %h exp 1 800", s_cyc, s_adr); end
    apply_reset();
  endtask

  task automatic test_timeout();
    apply_reset();
    mi_cyc = 1; mi_stb = 1; mi_adr = 32'h500;
    step();
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if ({mi_err, s_cyc, s_stb} !== ((k == 8) ? 3'b100 : 3'b011)) begin errors++; $display("FAIL tmo_cycle%0d: err/cyc/stb got %b exp %b", k, {mi_err, s_cyc, s_stb}, (k == 8) ? 3'b100 : 3'b011); end
      if (k == 8) begin mi_cyc = 0; mi_stb = 0; end
      step();
    end
    #1;
    checks++; if ({s_cyc, mi_err} !== 2'b00) begin errors++; $display("FAIL tmo_idle: got %b exp 00", {s_cyc, mi_err}); end
    // Ack arriving on the would-be expiry cycle
    mi_cyc = 1; mi_stb = 1;
    step();
    for (int k = 1; k < 8; k++) step();
    s_ack = 1; #1;
    checks++; if ({mi_ack, mi_err, s_cyc} !== 3'b101) begin errors++; $display("FAIL tmo_ack_wins: ack/err/cyc got %b exp 101", {mi_ack, mi_err, s_cyc}); end
    step(); s_ack = 0; #1;
    checks++; if ({mi_err, s_cyc} !== 2'b01) begin errors++; $display("FAIL tmo_after_ack: err/cyc got %b exp 01", {mi_err, s_cyc}); end
    mi_cyc = 0; mi_stb = 0;
    step();
    apply_reset();
  endtask

  task automatic test_err_and_reset();
    apply_reset();
    md_cyc = 1; md_stb = 1; md_we = 0; md_adr = 32'h600;
    step();
    s_err = 1; #1;
    checks++; if ({md_err, mi_err, md_ack} !== 3'b100) begin errors++; $display("FAIL serr_route: md_err/mi_err/md_ack got %b exp 100", {md_err, mi_err, md_ack}); end
    step(); s_err = 0; #1;
    checks++; if ({s_cyc, s_adr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL serr_keep_grant: got %b %h exp 1 600", s_cyc, s_adr); end
    mi_cyc = 1; mi_stb = 1; mi_adr = 32'h700;
    step(); s_ack = 1; rst = 1; #1;
    checks++; if ({s_cyc, s_stb, md_ack, mi_ack, md_err, mi_err} !== 6'b0) begin errors++; $display("FAIL rst_mid: got %b exp 000000", {s_cyc, s_stb, md_ack, mi_ack, md_err, mi_err}); end
    checks++; if (s_adr !== 32'h0) begin errors++; $display("FAIL rst_mid_adr: got %h exp 0", s_adr); end
    step(); s_ack = 0; rst = 0; #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_release_idle: s_cyc got %b exp 0", s_cyc); end
    step(); #1;
    checks++; if ({s_cyc, s_adr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL rst_tie_to_d: got %b %h exp 1 600", s_cyc, s_adr); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_round_robin();
    test_burst_no_preempt();
    test_timeout();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
